rf_write_scheduler: RTL and testbench
=====================================

RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 Parameter BUF_DEPTH, default 2: entries in the long-latency result buffer (>=1).
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive WB-won cycles after which a buffered result takes priority (>=1).
REQ-003 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 i_issue_valid  in  1  instruction in ID requests issue.
REQ-006 i_issue_rs, i_issue_rt, i_issue_rd  in  5 each  source and destination register numbers.
REQ-007 i_issue_use_rs, i_issue_use_rt, i_issue_wr  in  1 each  source used; instruction writes rd.
REQ-008 i_issue_long  in  1  instruction is a long-latency (multiply/divide unit) op.
REQ-009 o_stall  out  1  combinational; ID must hold; the issue is not accepted.
REQ-010 i_wb_we, i_wb_reg, i_wb_data  in  1/5/32  pipeline write-back request.
REQ-011 o_pipe_hold  out  1  combinational; the WB request is not taken this cycle and must be held.
REQ-012 i_mdu_valid, i_mdu_reg, i_mdu_data  in  1/5/32  long-latency result offered.
REQ-013 o_mdu_ready  out  1  result is accepted when valid&ready.
REQ-014 o_RegWrite, o_Write_reg, o_Write_data  out  1/5/32  registered register-file write port.

Function
REQ-015 Busy scoreboard: 32 bits; bit 0 is never set.
REQ-016 A busy bit for rd != 0 is set on the rising edge when i_issue_valid & !o_stall & i_issue_long & i_issue_wr.
REQ-017 A busy bit is cleared on the rising edge at which o_RegWrite rises for a buffered-result commit to that register; if a set and a clear of the same bit occur on one edge, the set wins.
REQ-018 o_stall = i_issue_valid & ((use_rs & busy[rs]) | (use_rt & busy[rt]) | (wr & busy[rd]) | (long & buffer full)).
REQ-019 Result buffer: FIFO of BUF_DEPTH {reg, data}; o_mdu_ready = !full, with no bypass and no push-when-full even if a pop occurs in the same cycle.
REQ-020 An accepted result is written into the FIFO on the edge and is eligible to commit from the following cycle.
REQ-021 Per-cycle arbitration, default: if i_wb_we, the WB request is selected; otherwise, if the FIFO is non-empty, the head is selected and popped.
REQ-022 Starvation counter: increments when the FIFO is non-empty and WB wins; resets to 0 on a FIFO pop or when the FIFO is empty; saturates at STARVE_LIMIT.
REQ-023 When counter == STARVE_LIMIT and the FIFO is non-empty, the head is selected and o_pipe_hold = i_wb_we; otherwise o_pipe_hold = 0.
REQ-024 The selected request is registered into o_RegWrite/o_Write_reg/o_Write_data on the next rising edge; with no selection, o_RegWrite = 0 and the register/data outputs hold their last values.
REQ-025 Latency: the WB request reaches the outputs 1 edge after it is presented; an MDU result reaches the outputs 2 edges after acceptance if uncontested.
REQ-026 Writes to register 0 are forwarded to the port unchanged and affect no scoreboard bit.
REQ-027 A result whose register is not busy is still committed; the scoreboard is unchanged.

Reset
REQ-028 While i_rst_n = 0: all busy bits 0; FIFO empty; starvation counter 0; o_RegWrite = 0; o_Write_reg = 0; o_Write_data = 0.
REQ-029 Reset asserted mid-operation discards buffered results and pending busy bits immediately, without waiting for a clock edge.
REQ-030 After release, o_mdu_ready = 1 and o_stall depends only on the issue inputs.

Verification
REQ-031 Long op issued with rd = 8, then a consumer with rs = 8 -> o_stall = 1 until the edge committing reg 8, then 0 in that cycle.
REQ-032 MDU result {9, 0x1234_5678} accepted with WB idle -> o_RegWrite = 1, o_Write_reg = 9, o_Write_data = 0x1234_5678 two edges later.
REQ-033 i_wb_we held 1 continuously with one buffered result -> WB is committed for 4 cycles, then buffer commits with o_pipe_hold = 1 for one cycle, then WB resumes.
REQ-034 Two results accepted back-to-back while WB busy (BUF_DEPTH = 2) -> o_mdu_ready = 0; a third valid is not accepted; a long issue stalls.
REQ-035 Issue with long = 1 and rd = 0 -> no busy bit set; a following rs = 0 consumer does not stall.
REQ-036 i_rst_n pulsed low with 2 buffered results and busy[5] = 1 -> FIFO empty, busy cleared, and o_RegWrite = 0 during reset and after release.

Source files
------------

// File: rtl/rf_write_scheduler_if.sv
// Bundle of the issue, write-back, long-latency result and register-file
// write-port signals shared between the pipeline and the write scheduler.
interface rf_write_scheduler_if;
  // Issue request from ID
  logic        i_issue_valid;
  logic [4:0]  i_issue_rs;
  logic [4:0]  i_issue_rt;
  logic [4:0]  i_issue_rd;
  logic        i_issue_use_rs;
  logic        i_issue_use_rt;
  logic        i_issue_wr;
  logic        i_issue_long;
  logic        o_stall;

  // Pipeline write-back request
  logic        i_wb_we;
  logic [4:0]  i_wb_reg;
  logic [31:0] i_wb_data;
  logic        o_pipe_hold;

  // Long-latency unit result handshake
  logic        i_mdu_valid;
  logic [4:0]  i_mdu_reg;
  logic [31:0] i_mdu_data;
  logic        o_mdu_ready;

  // Registered register-file write port
  logic        o_RegWrite;
  logic [4:0]  o_Write_reg;
  logic [31:0] o_Write_data;

  // Pipeline side: drives requests, observes stall/hold/ready and the write port
  modport master (
    output i_issue_valid, i_issue_rs, i_issue_rt, i_issue_rd,
    output i_issue_use_rs, i_issue_use_rt, i_issue_wr, i_issue_long,
    output i_wb_we, i_wb_reg, i_wb_data,
    output i_mdu_valid, i_mdu_reg, i_mdu_data,
    input  o_stall, o_pipe_hold, o_mdu_ready,
    input  o_RegWrite, o_Write_reg, o_Write_data
  );

  // Scheduler side
  modport slave (
    input  i_issue_valid, i_issue_rs, i_issue_rt, i_issue_rd,
    input  i_issue_use_rs, i_issue_use_rt, i_issue_wr, i_issue_long,
    input  i_wb_we, i_wb_reg, i_wb_data,
    input  i_mdu_valid, i_mdu_reg, i_mdu_data,
    output o_stall, o_pipe_hold, o_mdu_ready,
    output o_RegWrite, o_Write_reg, o_Write_data
  );
endinterface

// File: rtl/rf_write_scheduler.sv
// Register-file write scheduler: busy scoreboard for long-latency destinations,
// a small result FIFO for long-latency results, and a single write port shared
// between pipeline write-back and buffered results with starvation protection.
module rf_write_scheduler #(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  rf_write_scheduler_if.slave bus
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  // Scoreboard
  logic [31:0]       busy_reg;
  logic [31:0]       busy_next;
  logic [31:0]       set_mask;
  logic [31:0]       clr_mask;

  // Result FIFO (head is read combinationally; the write port is the register stage)
  logic [4:0]        fifo_reg_mem  [BUF_DEPTH];
  logic [31:0]       fifo_data_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [4:0]        head_reg;
  logic [31:0]       head_data;

  // Arbitration
  logic [STV_W-1:0]  starve_reg;
  logic [STV_W-1:0]  starve_next;
  logic              fifo_empty;
  logic              fifo_full;
  logic              starving;
  logic              push;
  logic              pop;
  logic              sel_wb;
  logic              issue_long_accept;

  // Write port registers
  logic              regwrite_reg;
  logic [4:0]        write_reg_reg;
  logic [31:0]       write_data_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(BUF_DEPTH));
  assign head_reg   = fifo_reg_mem[rd_ptr_reg];
  assign head_data  = fifo_data_mem[rd_ptr_reg];

  // No bypass: a full FIFO refuses a result even when it pops this cycle
  assign bus.o_mdu_ready = !fifo_full;
  assign push            = bus.i_mdu_valid && !fifo_full;

  // Buffered result wins when WB is idle or it has waited STARVE_LIMIT cycles
  assign starving        = (starve_reg == STV_W'(STARVE_LIMIT)) && !fifo_empty;
  assign pop             = !fifo_empty && (starving || !bus.i_wb_we);
  assign sel_wb          = bus.i_wb_we && !pop;
  assign bus.o_pipe_hold = starving && bus.i_wb_we;

  assign bus.o_stall = bus.i_issue_valid && (
                         (bus.i_issue_use_rs && busy_reg[bus.i_issue_rs]) ||
                         (bus.i_issue_use_rt && busy_reg[bus.i_issue_rt]) ||
                         (bus.i_issue_wr     && busy_reg[bus.i_issue_rd]) ||
                         (bus.i_issue_long   && fifo_full));

  assign issue_long_accept = bus.i_issue_valid && !bus.o_stall &&
                             bus.i_issue_long && bus.i_issue_wr;

  // Register 0 never gets a scoreboard bit
  assign set_mask[0] = 1'b0;
  assign clr_mask[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy_dec
      assign set_mask[gi] = issue_long_accept && (bus.i_issue_rd == 5'(gi));
      assign clr_mask[gi] = pop && (head_reg == 5'(gi));
    end
  endgenerate

  // Clear on commit of a buffered result, set on long issue; set wins on a tie
  always_comb begin
    busy_next = (busy_reg & ~clr_mask) | set_mask;
  end

  // Starvation counter: counts WB wins while a result waits, saturating
  always_comb begin
    starve_next = starve_reg;
    if (fifo_empty || pop) begin
      starve_next = '0;
    end else if (sel_wb && (starve_reg != STV_W'(STARVE_LIMIT))) begin
      starve_next = starve_reg + 1'b1;
    end
  end

  // FIFO storage: write-only array, no reset needed since occupancy gates reads
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_reg_mem[wr_ptr_reg]  <= bus.i_mdu_reg;
      fifo_data_mem[wr_ptr_reg] <= bus.i_mdu_data;
    end
  end

  // FIFO pointers, occupancy, scoreboard and starvation state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      busy_reg   <= '0;
      starve_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      busy_reg   <= busy_next;
      starve_reg <= starve_next;
    end
  end

  // Write port: register the selected request, hold reg/data when idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regwrite_reg   <= 1'b0;
      write_reg_reg  <= '0;
      write_data_reg <= '0;
    end else if (pop) begin
      regwrite_reg   <= 1'b1;
      write_reg_reg  <= head_reg;
      write_data_reg <= head_data;
    end else if (sel_wb) begin
      regwrite_reg   <= 1'b1;
      write_reg_reg  <= bus.i_wb_reg;
      write_data_reg <= bus.i_wb_data;
    end else begin
      regwrite_reg   <= 1'b0;
    end
  end

  assign bus.o_RegWrite   = regwrite_reg;
  assign bus.o_Write_reg  = write_reg_reg;
  assign bus.o_Write_data = write_data_reg;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_rf_write_scheduler;

  localparam int BUF_DEPTH    = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_write_scheduler_if bus();

  rf_write_scheduler #(.BUF_DEPTH(BUF_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_busy [32];
  logic [4:0]  q_reg  [$];
  logic [31:0] q_data [$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          hold_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_issue_valid  = 1'b0;
    bus.i_issue_rs     = '0;
    bus.i_issue_rt     = '0;
    bus.i_issue_rd     = '0;
    bus.i_issue_use_rs = 1'b0;
    bus.i_issue_use_rt = 1'b0;
    bus.i_issue_wr     = 1'b0;
    bus.i_issue_long   = 1'b0;
    bus.i_wb_we        = 1'b0;
    bus.i_wb_reg       = '0;
    bus.i_wb_data      = '0;
    bus.i_mdu_valid    = 1'b0;
    bus.i_mdu_reg      = '0;
    bus.i_mdu_data     = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    q_reg.delete();
    q_data.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_reg    = '0;
    m_data   = '0;
  endtask

  // One clock cycle: check combinational outputs, advance model, check write port
  task automatic step();
    int   sz;
    bit   full;
    bit   e_stall;
    bit   starving;
    bit   buf_sel;
    bit   e_hold;
    #1;
    sz       = q_reg.size();
    full     = (sz == BUF_DEPTH);
    e_stall  = bus.i_issue_valid &&
               ((bus.i_issue_use_rs && m_busy[bus.i_issue_rs]) ||
                (bus.i_issue_use_rt && m_busy[bus.i_issue_rt]) ||
                (bus.i_issue_wr     && m_busy[bus.i_issue_rd]) ||
                (bus.i_issue_long   && full));
    starving = (m_starve == STARVE_LIMIT) && (sz > 0);
    buf_sel  = (sz > 0) && (starving || !bus.i_wb_we);
    e_hold   = starving && bus.i_wb_we;
    chk("stall", bus.o_stall, e_stall);
    chk("pipe_hold", bus.o_pipe_hold, e_hold);
    chk("mdu_ready", bus.o_mdu_ready, !full);
    if (bus.o_pipe_hold) hold_seen++;

    if (buf_sel) begin
      m_we   = 1'b1;
      m_reg  = q_reg.pop_front();
      m_data = q_data.pop_front();
      if (m_reg != 0) m_busy[m_reg] = 1'b0;
      m_starve = 0;
    end else if (bus.i_wb_we) begin
      m_we     = 1'b1;
      m_reg    = bus.i_wb_reg;
      m_data   = bus.i_wb_data;
      m_starve = (sz > 0) ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT) : 0;
    end else begin
      m_we     = 1'b0;
      m_starve = 0;
    end
    if (bus.i_issue_valid && !e_stall && bus.i_issue_long && bus.i_issue_wr &&
        bus.i_issue_rd != 0)
      m_busy[bus.i_issue_rd] = 1'b1;
    if (bus.i_mdu_valid && !full) begin
      q_reg.push_back(bus.i_mdu_reg);
      q_data.push_back(bus.i_mdu_data);
    end

    @(posedge clk);
    #1;
    chk("RegWrite", bus.o_RegWrite, m_we);
    chk("Write_reg", bus.o_Write_reg, m_reg);
    chk("Write_data", bus.o_Write_data, m_data);
    $display("cyc t=%0t we=%0b reg=%0d data=%08h fifo=%0d", $time,
             bus.o_RegWrite, bus.o_Write_reg, bus.o_Write_data, q_reg.size());
  endtask

  initial begin
    clear_inputs();
    model_reset();
    hold_seen = 0;

    // Reset state
    #3;
    chk("rst_regwrite", bus.o_RegWrite, 1'b0);
    chk("rst_write_reg", bus.o_Write_reg, 5'd0);
    chk("rst_write_data", bus.o_Write_data, 32'd0);
    chk("rst_ready", bus.o_mdu_ready, 1'b1);
    #9;
    rst_n = 1'b1;

    // After release: a consumer of any register does not stall
    bus.i_issue_valid = 1'b1; bus.i_issue_use_rs = 1'b1; bus.i_issue_rs = 5'd5;
    step();

    // MDU result {9, 0x12345678} with WB idle reaches the port two edges later
    clear_inputs();
    bus.i_mdu_valid = 1'b1; bus.i_mdu_reg = 5'd9; bus.i_mdu_data = 32'h1234_5678;
    step();
    clear_inputs();
    step();
    chk("r032_we", bus.o_RegWrite, 1'b1);
    chk("r032_reg", bus.o_Write_reg, 5'd9);
    chk("r032_data", bus.o_Write_data, 32'h1234_5678);

    // Long op to r8, consumer of r8 stalls until r8 commits
    clear_inputs();
    bus.i_issue_valid = 1'b1; bus.i_issue_long = 1'b1; bus.i_issue_wr = 1'b1;
    bus.i_issue_rd = 5'd8;
    step();
    clear_inputs();
    bus.i_issue_valid = 1'b1; bus.i_issue_use_rs = 1'b1; bus.i_issue_rs = 5'd8;
    #1;
    chk("r031_stall", bus.o_stall, 1'b1);
    step();
    bus.i_mdu_valid = 1'b1; bus.i_mdu_reg = 5'd8; bus.i_mdu_data = 32'hCAFE_0008;
    step();
    bus.i_mdu_valid = 1'b0;
    step();
    chk("r031_release", bus.o_stall, 1'b0);
    chk("r031_commit_reg", bus.o_Write_reg, 5'd8);
    step();

    // Long issue to r0 sets nothing; r0 consumer does not stall
    clear_inputs();
    bus.i_issue_valid = 1'b1; bus.i_issue_long = 1'b1; bus.i_issue_wr = 1'b1;
    bus.i_issue_rd = 5'd0;
    step();
    clear_inputs();
    bus.i_issue_valid = 1'b1; bus.i_issue_use_rs = 1'b1; bus.i_issue_rs = 5'd0;
    #1;
    chk("r035_stall", bus.o_stall, 1'b0);
    step();

    // Continuous WB with one buffered result: 4 WB commits, then buffer with hold
    clear_inputs();
    bus.i_wb_we = 1'b1; bus.i_wb_reg = 5'd3; bus.i_wb_data = 32'hB000_0000;
    bus.i_mdu_valid = 1'b1; bus.i_mdu_reg = 5'd12; bus.i_mdu_data = 32'hAAAA_0012;
    step();
    bus.i_mdu_valid = 1'b0;
    hold_seen = 0;
    for (int i = 0; i < 7; i++) begin
      bus.i_wb_data = 32'hB000_0001 + i;
      step();
      chk("r033_order", bus.o_Write_reg, (i == 4) ? 5'd12 : 5'd3);
    end
    chk("r033_hold_cycles", hold_seen, 1);

    // Two results accepted back-to-back while WB busy: FIFO full
    bus.i_mdu_valid = 1'b1; bus.i_mdu_reg = 5'd13; bus.i_mdu_data = 32'hD000_0013;
    step();
    bus.i_mdu_reg = 5'd14; bus.i_mdu_data = 32'hD000_0014;
    step();
    bus.i_mdu_reg = 5'd15; bus.i_mdu_data = 32'hD000_0015;
    bus.i_issue_valid = 1'b1; bus.i_issue_long = 1'b1; bus.i_issue_wr = 1'b1;
    bus.i_issue_rd = 5'd4;
    #1;
    chk("r034_ready", bus.o_mdu_ready, 1'b0);
    chk("r034_stall", bus.o_stall, 1'b1);
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) step();

    // Async reset with two buffered results and busy[5]
    clear_inputs();
    bus.i_issue_valid = 1'b1; bus.i_issue_long = 1'b1; bus.i_issue_wr = 1'b1;
    bus.i_issue_rd = 5'd5;
    bus.i_wb_we = 1'b1; bus.i_wb_reg = 5'd2; bus.i_wb_data = 32'hE000_0002;
    bus.i_mdu_valid = 1'b1; bus.i_mdu_reg = 5'd20; bus.i_mdu_data = 32'hF000_0020;
    step();
    bus.i_issue_valid = 1'b0; bus.i_issue_long = 1'b0; bus.i_issue_wr = 1'b0;
    bus.i_mdu_reg = 5'd21; bus.i_mdu_data = 32'hF000_0021;
    step();
    bus.i_mdu_valid = 1'b0;
    chk("r036_pre_we", bus.o_RegWrite, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r036_async_we", bus.o_RegWrite, 1'b0);
    chk("r036_async_reg", bus.o_Write_reg, 5'd0);
    chk("r036_async_data", bus.o_Write_data, 32'd0);
    chk("r036_async_ready", bus.o_mdu_ready, 1'b1);
    bus.i_issue_valid = 1'b1; bus.i_issue_use_rs = 1'b1; bus.i_issue_rs = 5'd5;
    bus.i_issue_long = 1'b1;
    #1;
    chk("r036_busy_cleared", bus.o_stall, 1'b0);
    @(posedge clk);
    #1;
    chk("r036_held_we", bus.o_RegWrite, 1'b0);
    #3;
    rst_n = 1'b1;
    model_reset();
    clear_inputs();
    step();
    bus.i_issue_valid = 1'b1; bus.i_issue_use_rs = 1'b1; bus.i_issue_rs = 5'd5;
    step();

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      bus.i_issue_valid  = 1'($urandom_range(0, 1));
      bus.i_issue_rs     = 5'($urandom_range(0, 7));
      bus.i_issue_rt     = 5'($urandom_range(0, 7));
      bus.i_issue_rd     = 5'($urandom_range(0, 7));
      bus.i_issue_use_rs = 1'($urandom_range(0, 1));
      bus.i_issue_use_rt = 1'($urandom_range(0, 1));
      bus.i_issue_wr     = 1'($urandom_range(0, 1));
      bus.i_issue_long   = ($urandom_range(0, 2) == 0);
      bus.i_wb_we        = ($urandom_range(0, 2) != 0);
      bus.i_wb_reg       = 5'($urandom_range(0, 31));
      bus.i_wb_data      = $urandom;
      bus.i_mdu_valid    = 1'($urandom_range(0, 1));
      bus.i_mdu_reg      = 5'($urandom_range(0, 7));
      bus.i_mdu_data     = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
